// File: rtl/exc_pkg.sv
//------------------------------------------------------------------------------
// Module   : exc_pkg
// Purpose  : Shared cause codes, handler vectors, fatal codes and FSM states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package exc_pkg;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;
    localparam logic [1:0] CAUSE_DIV0    = 2'b01;
    localparam logic [1:0] CAUSE_LS      = 2'b10;
    localparam logic [1:0] CAUSE_ADDR    = 2'b11;

    localparam logic [15:0] VEC_ILLEGAL = 16'h02BC;
    localparam logic [15:0] VEC_DIV0    = 16'h030C;
    localparam logic [15:0] VEC_LS      = 16'h02E4;
    localparam logic [15:0] VEC_ADDR    = 16'h0334;

    localparam logic [1:0] FATAL_NESTED  = 2'b01;
    localparam logic [1:0] FATAL_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4,
        ST_HALT     = 3'd5
    } exc_state_t;

endpackage

`default_nettype wire

// File: rtl/exc_vector_lut.sv
//------------------------------------------------------------------------------
// Module   : exc_vector_lut
// Purpose  : Combinational cause-to-handler-vector lookup.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exc_vector_lut
    import exc_pkg::*;
(
    input  logic [1:0]  cause,
    output logic [15:0] vector
);

    always_comb begin
        vector = 16'h0000;
        case (cause)
            CAUSE_ILLEGAL: vector = VEC_ILLEGAL;
            CAUSE_DIV0:    vector = VEC_DIV0;
            CAUSE_LS:      vector = VEC_LS;
            CAUSE_ADDR:    vector = VEC_ADDR;
            default:       vector = 16'h0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exc_ctrl.sv
//------------------------------------------------------------------------------
// Module   : exc_ctrl
// Purpose  : Exception sequencer: flush, redirect to handler, ERET return.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exc_ctrl
    import exc_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 64,
    parameter int CNT_W         = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_valid,
    input  logic             commit_exc,
    input  logic [1:0]       commit_cause,
    input  logic [31:0]      commit_pc,
    input  logic             commit_eret,
    input  logic             flush_done,
    output logic             flush_req,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      epc,
    output logic [1:0]       cause,
    output logic             in_handler,
    output logic             busy,
    output logic             fatal,
    output logic [1:0]       fatal_code,
    output logic [CNT_W-1:0] exc_count [4]
);

    localparam int TO_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

    exc_state_t       r_state;
    exc_state_t       w_next_state;
    logic [TO_W-1:0]  r_to_cnt;
    logic [31:0]      r_epc;
    logic [1:0]       r_cause;
    logic [31:0]      r_redirect_pc;
    logic [1:0]       r_fatal_code;
    logic [CNT_W-1:0] r_exc_count [4];
    logic [15:0]      w_vector;
    logic             w_exc;
    logic             w_eret;
    logic             w_timeout;

    assign w_exc     = commit_valid & commit_exc;
    assign w_eret    = commit_valid & commit_eret;
    assign w_timeout = (r_to_cnt == TO_W'(FLUSH_TIMEOUT - 1));

    exc_vector_lut u_vector_lut (
        .cause  (r_cause),
        .vector (w_vector)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_exc) w_next_state = ST_FLUSH;
            ST_FLUSH: begin
                if (flush_done)     w_next_state = ST_REDIRECT;
                else if (w_timeout) w_next_state = ST_HALT;
            end
            ST_REDIRECT: w_next_state = ST_HANDLER;
            ST_HANDLER: begin
                // A nested exception outranks a simultaneous ERET.
                if (w_exc)       w_next_state = ST_HALT;
                else if (w_eret) w_next_state = ST_RETURN;
            end
            ST_RETURN:   w_next_state = ST_IDLE;
            ST_HALT:     w_next_state = ST_HALT;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_epc         <= '0;
            r_cause       <= '0;
            r_redirect_pc <= '0;
            r_fatal_code  <= '0;
            for (int i = 0; i < 4; i++) r_exc_count[i] <= '0;
        end else begin
            r_to_cnt <= (r_state == ST_FLUSH) ? r_to_cnt + TO_W'(1) : '0;

            if (r_state == ST_IDLE && w_exc) begin
                r_epc   <= commit_pc;
                r_cause <= commit_cause;
                if (!(&r_exc_count[commit_cause]))
                    r_exc_count[commit_cause] <= r_exc_count[commit_cause] + CNT_W'(1);
            end

            // Target is captured on the edge entering the pulse state so it
            // is stable for the whole pulse and held afterwards.
            if (w_next_state == ST_REDIRECT && r_state == ST_FLUSH)
                r_redirect_pc <= {16'h0000, w_vector};
            if (w_next_state == ST_RETURN && r_state == ST_HANDLER)
                r_redirect_pc <= r_epc + 32'd4;

            if (w_next_state == ST_HALT && r_state != ST_HALT)
                r_fatal_code <= (r_state == ST_HANDLER) ? FATAL_NESTED : FATAL_TIMEOUT;
        end
    end

    assign flush_req      = (r_state == ST_FLUSH) || (r_state == ST_HALT);
    assign redirect_valid = (r_state == ST_REDIRECT) || (r_state == ST_RETURN);
    assign redirect_pc    = r_redirect_pc;
    assign epc            = r_epc;
    assign cause          = r_cause;
    assign in_handler     = (r_state == ST_HANDLER);
    assign busy           = (r_state != ST_IDLE);
    assign fatal          = (r_state == ST_HALT);
    assign fatal_code     = r_fatal_code;
    assign exc_count      = r_exc_count;

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_exc_ctrl
// Purpose  : Directed self-checking bench for exc_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid = 1'b0;
    logic        commit_exc = 1'b0;
    logic [1:0]  commit_cause = 2'b00;
    logic [31:0] commit_pc = 32'h0;
    logic        commit_eret = 1'b0;
    logic        flush_done = 1'b0;
    logic        flush_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        in_handler;
    logic        busy;
    logic        fatal;
    logic [1:0]  fatal_code;
    logic [7:0]  exc_count [4];

    int pass_cnt  = 0;
    int total_cnt = 0;

    exc_ctrl #(.FLUSH_TIMEOUT(64), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .commit_valid   (commit_valid),
        .commit_exc     (commit_exc),
        .commit_cause   (commit_cause),
        .commit_pc      (commit_pc),
        .commit_eret    (commit_eret),
        .flush_done     (flush_done),
        .flush_req      (flush_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epc            (epc),
        .cause          (cause),
        .in_handler     (in_handler),
        .busy           (busy),
        .fatal          (fatal),
        .fatal_code     (fatal_code),
        .exc_count      (exc_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid = 1'b0;
        commit_exc   = 1'b0;
        commit_eret  = 1'b0;
        commit_cause = 2'b00;
        flush_done   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [104:0] all_outs();
        return {flush_req, redirect_valid, redirect_pc, epc, cause, in_handler,
                busy, fatal, fatal_code, exc_count[0], exc_count[1],
                exc_count[2], exc_count[3]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total_cnt++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outs());
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy got %0b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        apply_reset();
        commit_valid = 1'b1; commit_exc = 1'b1;
        commit_cause = 2'b00; commit_pc = 32'h0000_0120;
        flush_done = 1'b1;
        step();
        commit_valid = 1'b0; commit_exc = 1'b0;
        total_cnt++;
        if (flush_req !== 1'b1) $display("FAIL ill_flush_req: got %0b want 1", flush_req);
        else pass_cnt++;
        total_cnt++;
        if (epc !== 32'h120 || cause !== 2'b00)
            $display("FAIL ill_epc_cause: got %h/%0d want 120/0", epc, cause);
        else pass_cnt++;
        total_cnt++;
        if (exc_count[0] !== 8'd1) $display("FAIL ill_count: got %0d want 1", exc_count[0]);
        else pass_cnt++;
        step();
        flush_done = 1'b0;
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_02BC)
            $display("FAIL ill_redirect: got %0b/%h want 1/000002bc", redirect_valid, redirect_pc);
        else pass_cnt++;
        step();
        total_cnt++;
        if (in_handler !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0000_02BC)
            $display("FAIL ill_handler: got ih=%0b rv=%0b pc=%h want 1/0/000002bc",
                     in_handler, redirect_valid, redirect_pc);
        else pass_cnt++;
    endtask

    task automatic test_div0_eret();
        apply_reset();
        commit_valid = 1'b1; commit_exc = 1'b1;
        commit_cause = 2'b01; commit_pc = 32'h0000_0120;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        total_cnt++;
        if (flush_req !== 1'b1 || redirect_valid !== 1'b0)
            $display("FAIL div0_wait_flush: got fr=%0b rv=%0b want 1/0", flush_req, redirect_valid);
        else pass_cnt++;
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_030C)
            $display("FAIL div0_vector: got %0b/%h want 1/0000030c", redirect_valid, redirect_pc);
        else pass_cnt++;
        step();
        commit_valid = 1'b1; commit_eret = 1'b1;
        step();
        idle_inputs();
        total_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0124)
            $display("FAIL div0_return: got %0b/%h want 1/00000124", redirect_valid, redirect_pc);
        else pass_cnt++;
        step();
        total_cnt++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0 || exc_count[1] !== 8'd1)
            $display("FAIL div0_idle: got busy=%0b rv=%0b cnt1=%0d want 0/0/1",
                     busy, redirect_valid, exc_count[1]);
        else pass_cnt++;
    endtask

    task automatic test_nested();
        int redirects;
        apply_reset();
        commit_valid = 1'b1; commit_exc = 1'b1;
        commit_cause = 2'b10; commit_pc = 32'h0000_0200;
        flush_done = 1'b1;
        step();
        idle_inputs();
        flush_done = 1'b1;
        step();
        flush_done = 1'b0;
        total_cnt++;
        if (redirect_pc !== 32'h0000_02E4) $display("FAIL nest_vector: got %h want 000002e4", redirect_pc);
        else pass_cnt++;
        step();
        commit_valid = 1'b1; commit_exc = 1'b1; commit_eret = 1'b1;
        commit_cause = 2'b11; commit_pc = 32'h0000_0999;
        step();
        total_cnt++;
        if (fatal !== 1'b1 || fatal_code !== 2'b01)
            $display("FAIL nest_fatal: got %0b/%b want 1/01", fatal, fatal_code);
        else pass_cnt++;
        total_cnt++;
        if (epc !== 32'h200 || cause !== 2'b10 || exc_count[3] !== 8'd0)
            $display("FAIL nest_saved: got epc=%h cause=%0d cnt3=%0d want 200/2/0",
                     epc, cause, exc_count[3]);
        else pass_cnt++;
        commit_exc = 1'b0;
        redirects = 0;
        for (int i = 0; i < 6; i++) begin
            if (redirect_valid !== 1'b0 || flush_req !== 1'b1 || fatal !== 1'b1) redirects++;
            step();
        end
        idle_inputs();
        total_cnt++;
        if (redirects !== 0) $display("FAIL nest_halt_hold: got %0d bad cycles want 0", redirects);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        commit_valid = 1'b1; commit_exc = 1'b1;
        commit_cause = 2'b00; commit_pc = 32'h0000_0040;
        step();
        idle_inputs();
        n = 0;
        while (flush_req === 1'b1 && fatal === 1'b0 && n < 200) begin
            n++;
            step();
        end
        total_cnt++;
        if (n !== 64) $display("FAIL tmo_cycles: got %0d want 64", n);
        else pass_cnt++;
        total_cnt++;
        if (fatal !== 1'b1 || fatal_code !== 2'b10 || flush_req !== 1'b1)
            $display("FAIL tmo_fatal: got f=%0b code=%b fr=%0b want 1/10/1", fatal, fatal_code, flush_req);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [31:0] ret_pc;
        apply_reset();
        commit_pc  = 32'hFFFF_FFFC;
        flush_done = 1'b1;
        bad = 0;
        ret_pc = 32'h1;
        for (int i = 0; i < 300; i++) begin
            commit_valid = 1'b1; commit_exc = 1'b1; commit_cause = 2'b11;
            step();
            if (flush_req !== 1'b1) bad++;
            commit_valid = 1'b0; commit_exc = 1'b0;
            step();
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0334) bad++;
            step();
            commit_valid = 1'b1; commit_eret = 1'b1;
            step();
            if (redirect_valid !== 1'b1) bad++;
            ret_pc = redirect_pc;
            commit_valid = 1'b0; commit_eret = 1'b0;
            step();
            if (busy !== 1'b0) bad++;
        end
        idle_inputs();
        total_cnt++;
        if (bad !== 0) $display("FAIL b2b_sequence: got %0d bad steps want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (exc_count[3] !== 8'd255 || exc_count[0] !== 8'd0)
            $display("FAIL b2b_saturate: got cnt3=%0d cnt0=%0d want 255/0", exc_count[3], exc_count[0]);
        else pass_cnt++;
        total_cnt++;
        if (ret_pc !== 32'h0 || epc !== 32'hFFFF_FFFC)
            $display("FAIL b2b_wrap: got ret=%h epc=%h want 00000000/fffffffc", ret_pc, epc);
        else pass_cnt++;
    endtask

    task automatic test_mask_reset();
        apply_reset();
        commit_valid = 1'b1; commit_eret = 1'b1;
        step();
        total_cnt++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0)
            $display("FAIL mask_eret_idle: got busy=%0b rv=%0b want 0/0", busy, redirect_valid);
        else pass_cnt++;
        commit_valid = 1'b0; commit_eret = 1'b0; commit_exc = 1'b1;
        step();
        step();
        total_cnt++;
        if (all_outs() !== '0) $display("FAIL mask_invalid_exc: got %h want 0", all_outs());
        else pass_cnt++;
        commit_valid = 1'b1; commit_cause = 2'b01; commit_pc = 32'h0000_0500;
        step();
        idle_inputs();
        total_cnt++;
        if (flush_req !== 1'b1) $display("FAIL rst_pre_flush: got %0b want 1", flush_req);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (all_outs() !== '0) $display("FAIL rst_async: got %h want 0", all_outs());
        else pass_cnt++;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_div0_eret();
        test_nested();
        test_timeout();
        test_back_to_back();
        test_mask_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
